tc_bus_arbiter: RTL and testbench

- Shares one TC bus master port among NREQ requesters using round-robin arbitration.
- Tracks outstanding reads and writes in separate in-order ID FIFOs so each tc_rack/tc_wack is routed back to the requester that issued the transaction.
- Throttles new requests when MAX_OUT transactions are in flight and flags protocol violations.
- Sits between the client blocks and the TC bus target.

---
 rtl/tc_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_tc_bus_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_bus_arbiter.sv
// Round-robin arbiter sharing one TC bus master port among NREQ clients,
// routing read/write completions back through in-order ID FIFOs.
module tc_bus_arbiter #(
    parameter int NREQ      = 4,
    parameter int TC_AWIDTH = 8,
    parameter int TC_DWIDTH = 8,
    parameter int MAX_OUT   = 4,
    localparam int CW       = $clog2(MAX_OUT + 1)
) (
    input  logic                      clk_bus,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           m_req,
    input  logic [NREQ-1:0]           m_rnw,
    input  logic [NREQ*TC_AWIDTH-1:0] m_addr,
    input  logic [NREQ*TC_DWIDTH-1:0] m_wdata,
    output logic [NREQ-1:0]           m_aack,
    output logic [NREQ-1:0]           m_rack,
    output logic [NREQ-1:0]           m_wack,
    output logic                      tc_req,
    output logic                      tc_rnw,
    output logic [TC_AWIDTH-1:0]      tc_addr,
    output logic [TC_DWIDTH-1:0]      tc_wdata,
    input  logic                      tc_aack,
    input  logic                      tc_rack,
    input  logic                      tc_wack,
    output logic [CW-1:0]             rd_outstanding,
    output logic [CW-1:0]             wr_outstanding,
    output logic                      err_overflow,
    output logic                      err_unexp_ack
);

    localparam int IW = $clog2(NREQ);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [IW-1:0] rr;
    logic [IW-1:0] owner;
    logic [IW-1:0] pick;
    logic [IW-1:0] sel;
    logic          locked;
    logic          found;
    logic [CW:0]   total;
    logic          req;
    logic          accept;
    int            idx;

    logic [IW-1:0] rd_mem [MAX_OUT];
    logic [IW-1:0] wr_mem [MAX_OUT];
    logic [PW-1:0] rd_rp, rd_wp, wr_rp, wr_wp;
    logic [CW-1:0] rd_cnt, wr_cnt;

    logic rd_full, rd_empty, wr_full, wr_empty;
    logic push_rd, pop_rd, push_wr, pop_wr;
    logic wr_byp, ovf, unexp;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // first pending request at or after the rr pointer, wrapping
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr) + k) % NREQ;
            if (!found && m_req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    assign total  = {1'b0, rd_cnt} + {1'b0, wr_cnt};
    assign sel    = locked ? owner : pick;
    assign req    = rst_n & (locked | (found & (total < (CW+1)'(MAX_OUT))));
    assign accept = req & tc_aack;

    assign tc_req   = req;
    assign tc_rnw   = req & m_rnw[sel];
    assign tc_addr  = req ? m_addr[int'(sel)*TC_AWIDTH +: TC_AWIDTH] : '0;
    assign tc_wdata = req ? m_wdata[int'(sel)*TC_DWIDTH +: TC_DWIDTH] : '0;

    assign rd_full  = (rd_cnt == CW'(MAX_OUT));
    assign wr_full  = (wr_cnt == CW'(MAX_OUT));
    assign rd_empty = (rd_cnt == '0);
    assign wr_empty = (wr_cnt == '0);

    // a write completing in its own accept cycle never enters the FIFO
    assign wr_byp  = rst_n & accept & ~tc_rnw & wr_empty & tc_wack;
    assign push_rd = accept & tc_rnw & ~rd_full;
    assign push_wr = accept & ~tc_rnw & ~wr_full & ~wr_byp;
    assign pop_rd  = rst_n & tc_rack & ~rd_empty;
    assign pop_wr  = rst_n & tc_wack & ~wr_empty;
    assign ovf     = accept & (tc_rnw ? rd_full : wr_full);
    assign unexp   = rst_n & ((tc_rack & rd_empty)
                   | (tc_wack & wr_empty & ~wr_byp));

    assign m_aack = accept ? (NREQ'(1) << sel) : '0;
    assign m_rack = pop_rd ? (NREQ'(1) << rd_mem[rd_rp]) : '0;
    assign m_wack = pop_wr ? (NREQ'(1) << wr_mem[wr_rp])
                  : wr_byp ? (NREQ'(1) << sel) : '0;

    assign rd_outstanding = rd_cnt;
    assign wr_outstanding = wr_cnt;

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            rr            <= '0;
            owner         <= '0;
            locked        <= 1'b0;
            rd_rp         <= '0;
            rd_wp         <= '0;
            wr_rp         <= '0;
            wr_wp         <= '0;
            rd_cnt        <= '0;
            wr_cnt        <= '0;
            err_overflow  <= 1'b0;
            err_unexp_ack <= 1'b0;
        end else begin
            if (accept) begin
                locked <= 1'b0;
                rr     <= (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
            end else if (req && !locked) begin
                locked <= 1'b1;
                owner  <= sel;
            end
            if (push_rd) rd_wp <= nxt(rd_wp);
            if (pop_rd)  rd_rp <= nxt(rd_rp);
            if (push_wr) wr_wp <= nxt(wr_wp);
            if (pop_wr)  wr_rp <= nxt(wr_rp);
            rd_cnt        <= rd_cnt + CW'(push_rd) - CW'(pop_rd);
            wr_cnt        <= wr_cnt + CW'(push_wr) - CW'(pop_wr);
            err_overflow  <= err_overflow | ovf;
            err_unexp_ack <= err_unexp_ack | unexp;
        end
    end

    always_ff @(posedge clk_bus) begin
        if (push_rd) rd_mem[rd_wp] <= sel;
        if (push_wr) wr_mem[wr_wp] <= sel;
    end

endmodule

// File: tb/tb_tc_bus_arbiter.sv
// Bench for tc_bus_arbiter: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_tc_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MO = 4;
    localparam int CW = 3;

    logic            clk_bus = 1'b0;
    logic            rst_n   = 1'b0;
    logic [N-1:0]    m_req   = '0;
    logic [N-1:0]    m_rnw   = '0;
    logic [N*AW-1:0] m_addr  = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N-1:0]    m_aack, m_rack, m_wack;
    logic            tc_req, tc_rnw;
    logic [AW-1:0]   tc_addr;
    logic [DW-1:0]   tc_wdata;
    logic            tc_aack = 1'b0;
    logic            tc_rack = 1'b0;
    logic            tc_wack = 1'b0;
    logic [CW-1:0]   rd_outstanding, wr_outstanding;
    logic            err_overflow, err_unexp_ack;

    tc_bus_arbiter #(
        .NREQ(N), .TC_AWIDTH(AW), .TC_DWIDTH(DW), .MAX_OUT(MO)
    ) dut (
        .clk_bus(clk_bus), .rst_n(rst_n),
        .m_req(m_req), .m_rnw(m_rnw), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_aack(m_aack), .m_rack(m_rack), .m_wack(m_wack),
        .tc_req(tc_req), .tc_rnw(tc_rnw), .tc_addr(tc_addr),
        .tc_wdata(tc_wdata), .tc_aack(tc_aack), .tc_rack(tc_rack),
        .tc_wack(tc_wack), .rd_outstanding(rd_outstanding),
        .wr_outstanding(wr_outstanding), .err_overflow(err_overflow),
        .err_unexp_ack(err_unexp_ack)
    );

    always #5 clk_bus = ~clk_bus;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // reference model state
    int           rq[$];
    int           wq[$];
    int           rr_m = 0;
    bit           lk = 0;
    int           own = 0;
    bit           eo = 0;
    bit           eu = 0;
    logic [N-1:0] last_aack = '0;

    bit           ereq, acc, byp, unx, rfull, wfull;
    int           g;
    logic [N-1:0] ea, er, ew;

    always @(negedge clk_bus) begin
        if (!rst_n) begin
            rq.delete();
            wq.delete();
            rr_m = 0; lk = 0; own = 0; eo = 0; eu = 0;
            last_aack = '0;
            chk("rst_tc_req", 32'(tc_req), 0);
            chk("rst_aack", 32'(m_aack), 0);
            chk("rst_rack", 32'(m_rack), 0);
            chk("rst_wack", 32'(m_wack), 0);
            chk("rst_counts", 32'({rd_outstanding, wr_outstanding}), 0);
            chk("rst_errs", 32'({err_overflow, err_unexp_ack}), 0);
        end else begin
            ereq = 0;
            g    = 0;
            if (lk) begin
                ereq = 1;
                g    = own;
            end else if (rq.size() + wq.size() < MO) begin
                for (int k = 0; k < N; k++) begin
                    if (!ereq && m_req[(rr_m + k) % N]) begin
                        ereq = 1;
                        g    = (rr_m + k) % N;
                    end
                end
            end
            acc = ereq && tc_aack;
            ea  = acc ? N'(1 << g) : '0;
            er  = '0;
            ew  = '0;
            byp = 0;
            unx = 0;
            if (tc_rack) begin
                if (rq.size() > 0) er = N'(1 << rq[0]);
                else unx = 1;
            end
            if (tc_wack) begin
                if (wq.size() > 0) ew = N'(1 << wq[0]);
                else if (acc && !m_rnw[g]) begin
                    ew  = N'(1 << g);
                    byp = 1;
                end else unx = 1;
            end
            chk("tc_req", 32'(tc_req), 32'(ereq));
            if (ereq) begin
                chk("tc_rnw", 32'(tc_rnw), 32'(m_rnw[g]));
                chk("tc_addr", 32'(tc_addr), 32'(m_addr[g*AW +: AW]));
                chk("tc_wdata", 32'(tc_wdata), 32'(m_wdata[g*DW +: DW]));
            end
            chk("m_aack", 32'(m_aack), 32'(ea));
            chk("m_rack", 32'(m_rack), 32'(er));
            chk("m_wack", 32'(m_wack), 32'(ew));
            chk("rd_out", 32'(rd_outstanding), 32'(rq.size()));
            chk("wr_out", 32'(wr_outstanding), 32'(wq.size()));
            chk("err_ovf", 32'(err_overflow), 32'(eo));
            chk("err_unexp", 32'(err_unexp_ack), 32'(eu));
            rfull = (rq.size() == MO);
            wfull = (wq.size() == MO);
            if (tc_rack && rq.size() > 0) void'(rq.pop_front());
            if (tc_wack && wq.size() > 0) void'(wq.pop_front());
            if (acc) begin
                rr_m = (g + 1) % N;
                lk   = 0;
                if (m_rnw[g]) begin
                    if (rfull) eo = 1;
                    else rq.push_back(g);
                end else if (wfull) eo = 1;
                else if (!byp) wq.push_back(g);
            end else if (ereq) begin
                lk  = 1;
                own = g;
            end
            if (unx) eu = 1;
            last_aack = ea;
        end
    end

    task automatic tick();
        @(posedge clk_bus);
        #1;
    endtask

    task automatic setreq(input int i, input bit rnw, input logic [7:0] a,
                          input logic [7:0] d);
        m_req[i]           = 1'b1;
        m_rnw[i]           = rnw;
        m_addr[i*AW +: AW] = a;
        m_wdata[i*DW +: DW] = d;
    endtask

    task automatic idle();
        m_req   = '0;
        tc_aack = 0;
        tc_rack = 0;
        tc_wack = 0;
    endtask

    task automatic do_reset();
        tick();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    logic [N-1:0] rr_exp [5];

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        #2;
        chk("reset_tc_req", 32'(tc_req), 0);
        chk("reset_rd_out", 32'(rd_outstanding), 0);
        tick();
        rst_n = 1;

        // single read
        tick(); setreq(1, 1, 8'h3C, 8'h00); #1;
        chk("rd_c0_req", 32'(tc_req), 1);
        chk("rd_c0_addr", 32'(tc_addr), 32'h3C);
        tick(); #1;
        chk("rd_c1_addr", 32'(tc_addr), 32'h3C);
        tick(); tc_aack = 1; #1;
        chk("rd_c2_aack", 32'(m_aack), 32'b0010);
        tick(); idle(); #1;
        chk("rd_c3_out", 32'(rd_outstanding), 1);
        tick(); #1;
        chk("rd_c4_out", 32'(rd_outstanding), 1);
        tick(); tc_rack = 1; #1;
        chk("rd_c5_rack", 32'(m_rack), 32'b0010);
        chk("rd_c5_out", 32'(rd_outstanding), 1);
        tick(); tc_rack = 0; #1;
        chk("rd_c6_out", 32'(rd_outstanding), 0);

        // round robin with same-cycle write completions
        do_reset();
        tick();
        for (int i = 0; i < N; i++) setreq(i, 0, 8'(8'h40 + i), 8'(i));
        tc_aack = 1;
        tc_wack = 1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            #1;
            chk("rr_aack", 32'(m_aack), 32'(rr_exp[k]));
            chk("rr_wr_le1", 32'(wr_outstanding <= 1), 1);
        end
        tick(); idle();

        // lock holds the owner while the target stalls
        do_reset();
        tick(); setreq(0, 0, 8'h11, 8'hAA); #1;
        chk("lock_addr", 32'(tc_addr), 32'h11);
        for (int c = 1; c < 5; c++) begin
            tick();
            if (c == 1) setreq(2, 0, 8'h22, 8'hBB);
            #1;
            chk("lock_addr", 32'(tc_addr), 32'h11);
        end
        tick(); tc_aack = 1; #1;
        chk("lock_addr", 32'(tc_addr), 32'h11);
        chk("lock_aack0", 32'(m_aack), 32'b0001);
        tick(); m_req[0] = 0; #1;
        chk("lock_aack2", 32'(m_aack), 32'b0100);
        tick(); idle();

        // completion routing
        do_reset();
        tick(); setreq(1, 0, 8'h01, 8'h10); tc_aack = 1; #1;
        chk("rt_aack1", 32'(m_aack), 32'b0010);
        tick(); m_req = '0; setreq(2, 1, 8'h02, 8'h20); #1;
        chk("rt_aack2", 32'(m_aack), 32'b0100);
        tick(); m_req = '0; setreq(3, 0, 8'h03, 8'h30);
        tick(); m_req = '0; setreq(0, 1, 8'h04, 8'h40);
        tick(); m_req = '0; tc_aack = 0; tc_wack = 1; #1;
        chk("rt_wack1", 32'(m_wack), 32'b0010);
        tick(); tc_wack = 0; tc_rack = 1; #1;
        chk("rt_rack2", 32'(m_rack), 32'b0100);
        tick(); tc_rack = 0; tc_wack = 1; #1;
        chk("rt_wack3", 32'(m_wack), 32'b1000);
        tick(); tc_wack = 0; tc_rack = 1; #1;
        chk("rt_rack0", 32'(m_rack), 32'b0001);
        tick(); idle();

        // write bypass, then an unexpected read ack
        do_reset();
        tick(); setreq(3, 0, 8'h33, 8'h55); tc_aack = 1; tc_wack = 1; #1;
        chk("byp_wack", 32'(m_wack), 32'b1000);
        tick(); idle(); #1;
        chk("byp_wr_out", 32'(wr_outstanding), 0);
        chk("byp_no_err", 32'(err_unexp_ack), 0);
        tick(); tc_rack = 1; #1;
        chk("unexp_rack", 32'(m_rack), 0);
        tick(); tc_rack = 0; #1;
        chk("unexp_err", 32'(err_unexp_ack), 1);
        tick(); tick(); #1;
        chk("unexp_sticky", 32'(err_unexp_ack), 1);

        // throttle at MAX_OUT, then asynchronous reset mid-stream
        do_reset();
        tick(); setreq(2, 1, 8'h77, 8'h00); tc_aack = 1;
        tick(); tick(); tick();
        tick(); tc_aack = 0; #1;
        chk("thr_req_blk", 32'(tc_req), 0);
        chk("thr_rd_out", 32'(rd_outstanding), 4);
        tick(); tc_rack = 1; #1;
        chk("thr_same_cyc", 32'(tc_req), 0);
        chk("thr_rack", 32'(m_rack), 32'b0100);
        tick(); tc_rack = 0; #1;
        chk("thr_unblock", 32'(tc_req), 1);
        tick(); rst_n = 0; #1;
        chk("arst_req", 32'(tc_req), 0);
        chk("arst_rd", 32'(rd_outstanding), 0);
        chk("arst_aack", 32'(m_aack), 0);
        tick(); idle(); rst_n = 1;

        // random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (cyc == 1500) begin
                rst_n = 0;
                idle();
                continue;
            end
            if (cyc == 1501) rst_n = 1;
            for (int i = 0; i < N; i++) begin
                if (m_req[i] && !last_aack[i]) continue;
                if (m_req[i]) m_req[i] = 1'($urandom_range(0, 1));
                else if ($urandom_range(0, 3) == 0) m_req[i] = 1'b1;
                if (m_req[i]) begin
                    m_rnw[i]            = 1'($urandom_range(0, 1));
                    m_addr[i*AW +: AW]  = 8'($urandom);
                    m_wdata[i*DW +: DW] = 8'($urandom);
                end
            end
            tc_aack = 1'($urandom_range(0, 1));
            tc_rack = ($urandom_range(0, 3) == 0);
            tc_wack = ($urandom_range(0, 3) == 0);
        end
        tick(); idle();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
